foobar_multi: RTL and testbench

Parametrised multi-channel successor to the two-channel foo/bar divisibility generator. A free-running step counter advances on enabled cycles. Each of N_CH channels fires when the step is a multiple of its run-time divisor and counts its own fire events in wrap or saturate mode. A combined "all fired" flag and counter are also produced. The block sits under the foobar testbench family as the reusable event/tick source.

---
 rtl/foobar_multi.sv | 103 ++++++++++
 tb/tb_foobar_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/foobar_multi.sv
// Multi-channel divisibility tick generator: a free-running step counter plus per-channel
// phase trackers that pulse fire_o and count events, with a combined "all fired" flag/counter.
module foobar_multi #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned EV_W   = 8,
    parameter int unsigned STEP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   sat,
    input  logic [N_CH*DIV_W-1:0]  div_i,
    output logic [STEP_W-1:0]      step_o,
    output logic [N_CH-1:0]        fire_o,
    output logic                   all_o,
    output logic [N_CH*EV_W-1:0]   cnt_o,
    output logic [EV_W-1:0]        all_cnt_o
);

    logic [STEP_W-1:0]     step_q, step_d;
    logic [N_CH*DIV_W-1:0] phase_q, phase_d;
    logic [N_CH-1:0]       fire_q, fire_d;
    logic                  all_q, all_d;
    logic [N_CH*EV_W-1:0]  cnt_q, cnt_d;
    logic [EV_W-1:0]       all_cnt_q, all_cnt_d;

    logic [N_CH-1:0]       active;
    logic [DIV_W-1:0]      div_c, ph_c, ph_n;

    function automatic logic [EV_W-1:0] bump(input logic [EV_W-1:0] c, input logic s);
        return (s && (&c)) ? c : c + 1'b1;
    endfunction

    always_comb begin
        step_d    = step_q;
        phase_d   = phase_q;
        fire_d    = '0;
        all_d     = 1'b0;
        cnt_d     = cnt_q;
        all_cnt_d = all_cnt_q;
        active    = '0;
        div_c     = '0;
        ph_c      = '0;
        ph_n      = '0;
        if (en) begin
            step_d = step_q + 1'b1;
            for (int i = 0; i < int'(N_CH); i++) begin
                div_c     = div_i[i*DIV_W +: DIV_W];
                ph_c      = phase_q[i*DIV_W +: DIV_W];
                active[i] = (div_c != '0);
                // >= (not ==) so a shrunken divisor snaps the phase back to 0 next edge
                if (!active[i] || (ph_c >= div_c - 1'b1)) begin
                    ph_n = '0;
                end else begin
                    ph_n = ph_c + 1'b1;
                end
                phase_d[i*DIV_W +: DIV_W] = ph_n;
                fire_d[i] = active[i] && (ph_n == '0);
                if (fire_d[i]) begin
                    cnt_d[i*EV_W +: EV_W] = bump(cnt_q[i*EV_W +: EV_W], sat);
                end
            end
            all_d = (|active) && (&(fire_d | ~active));
            if (all_d) begin
                all_cnt_d = bump(all_cnt_q, sat);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q    <= '0;
            phase_q   <= '0;
            fire_q    <= '0;
            all_q     <= 1'b0;
            cnt_q     <= '0;
            all_cnt_q <= '0;
        end else if (clr) begin
            step_q    <= '0;
            phase_q   <= '0;
            fire_q    <= '0;
            all_q     <= 1'b0;
            cnt_q     <= '0;
            all_cnt_q <= '0;
        end else begin
            step_q    <= step_d;
            phase_q   <= phase_d;
            fire_q    <= fire_d;
            all_q     <= all_d;
            cnt_q     <= cnt_d;
            all_cnt_q <= all_cnt_d;
        end
    end

    assign step_o    = step_q;
    assign fire_o    = fire_q;
    assign all_o     = all_q;
    assign cnt_o     = cnt_q;
    assign all_cnt_o = all_cnt_q;

endmodule

// File: tb/tb_foobar_multi.sv
// Directed bench for foobar_multi: a behavioural model pushes expected outputs per edge and
// they are popped and compared after the edge; a second instance with STEP_W=4 checks wrap.
module tb_foobar_multi;

    logic        clk, rst, en, clr, sat;
    logic [15:0] div;
    logic [15:0] step_o;
    logic [1:0]  fire_o;
    logic        all_o;
    logic [15:0] cnt_o;
    logic [7:0]  all_cnt_o;
    logic [3:0]  step2_o;
    logic [1:0]  fire2_o;
    logic        all2_o;
    logic [15:0] cnt2_o;
    logic [7:0]  all_cnt2_o;

    int total = 0;
    int bad   = 0;

    foobar_multi #(.N_CH(2), .DIV_W(8), .EV_W(8), .STEP_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sat(sat), .div_i(div),
        .step_o(step_o), .fire_o(fire_o), .all_o(all_o), .cnt_o(cnt_o),
        .all_cnt_o(all_cnt_o)
    );

    foobar_multi #(.N_CH(2), .DIV_W(8), .EV_W(8), .STEP_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sat(sat), .div_i(div),
        .step_o(step2_o), .fire_o(fire2_o), .all_o(all2_o), .cnt_o(cnt2_o),
        .all_cnt_o(all_cnt2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] step;
        logic [3:0]  step4;
        logic [1:0]  fire;
        logic        all;
        logic [15:0] cnt;
        logic [7:0]  allc;
    } exp_t;

    exp_t sb_q[$];

    // Model: fire decided from the count of enabled edges since clear, not from a phase register.
    int m_e, m_step, m_allc;
    int m_cnt[2];
    logic [1:0] m_fire;
    logic       m_all;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_e = 0; m_step = 0; m_allc = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        m_fire = 2'b00; m_all = 1'b0;
    endtask

    function automatic int inc(input int c);
        if (sat) return (c == 255) ? 255 : c + 1;
        return (c + 1) % 256;
    endfunction

    task automatic edge_step(input logic e_in, input logic c_in);
        exp_t ex, got;
        int   d[2];
        logic any_act, all_f;
        en  = e_in;
        clr = c_in;
        d[0] = int'(div[7:0]);
        d[1] = int'(div[15:8]);
        if (c_in) begin
            m_reset();
        end else if (e_in) begin
            m_e++;
            m_step = (m_step + 1) % 65536;
            any_act = 1'b0;
            all_f   = 1'b1;
            for (int c = 0; c < 2; c++) begin
                m_fire[c] = (d[c] != 0) && (m_e % d[c] == 0);
                if (m_fire[c]) m_cnt[c] = inc(m_cnt[c]);
                if (d[c] != 0) begin
                    any_act = 1'b1;
                    if (!m_fire[c]) all_f = 1'b0;
                end
            end
            m_all = any_act && all_f;
            if (m_all) m_allc = inc(m_allc);
        end else begin
            m_fire = 2'b00;
            m_all  = 1'b0;
        end
        ex.step  = 16'(m_step);
        ex.step4 = 4'(m_step % 16);
        ex.fire  = m_fire;
        ex.all   = m_all;
        ex.cnt   = {8'(m_cnt[1]), 8'(m_cnt[0])};
        ex.allc  = 8'(m_allc);
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("step_o", 64'(step_o), 64'(got.step));
        chk("step4_o", 64'(step2_o), 64'(got.step4));
        chk("fire_o", 64'(fire_o), 64'(got.fire));
        chk("fire4_o", 64'(fire2_o), 64'(got.fire));
        chk("all_o", 64'(all_o), 64'(got.all));
        chk("cnt_o", 64'(cnt_o), 64'(got.cnt));
        chk("all_cnt_o", 64'(all_cnt_o), 64'(got.allc));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_step"}, 64'(step_o), 64'd0);
        chk({tag, "_fire"}, 64'(fire_o), 64'd0);
        chk({tag, "_all"}, 64'(all_o), 64'd0);
        chk({tag, "_cnt"}, 64'(cnt_o), 64'd0);
        chk({tag, "_allcnt"}, 64'(all_cnt_o), 64'd0);
        chk({tag, "_step4"}, 64'(step2_o), 64'd0);
        chk({tag, "_cnt4"}, 64'(cnt2_o), 64'd0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; sat = 1'b0; div = 16'h0503;
        m_reset();
        #12;
        check_zero("reset");
        rst = 1'b1;

        // 1: div=(3,5), wrap mode, 15 enabled edges
        for (int k = 0; k < 15; k++) edge_step(1'b1, 1'b0);
        chk("s1_fire", 64'(fire_o), 64'h3);
        chk("s1_all", 64'(all_o), 64'h1);
        chk("s1_cnt", 64'(cnt_o), 64'h0305);
        chk("s1_allcnt", 64'(all_cnt_o), 64'h1);

        // 2: div=(1,0), saturate then wrap over 300 edges
        div = 16'h0001; sat = 1'b1;
        edge_step(1'b0, 1'b1);
        for (int k = 0; k < 300; k++) edge_step(1'b1, 1'b0);
        chk("s2_sat_cnt", 64'(cnt_o), 64'h00ff);
        chk("s2_sat_allcnt", 64'(all_cnt_o), 64'd255);
        sat = 1'b0;
        edge_step(1'b0, 1'b1);
        for (int k = 0; k < 300; k++) edge_step(1'b1, 1'b0);
        chk("s2_wrap_cnt", 64'(cnt_o), 64'h002c);
        chk("s2_wrap_allcnt", 64'(all_cnt_o), 64'd44);

        // 3: en toggling every edge
        div = 16'h0503;
        edge_step(1'b0, 1'b1);
        for (int k = 0; k < 30; k++) begin
            edge_step(((k % 2) == 0), 1'b0);
            if ((k % 2) == 1) chk("s3_fire_after_idle", 64'(fire_o), 64'd0);
        end
        chk("s3_step", 64'(step_o), 64'd15);
        chk("s3_cnt", 64'(cnt_o), 64'h0305);

        // 4: clr together with en wins
        edge_step(1'b0, 1'b1);
        for (int k = 0; k < 7; k++) edge_step(1'b1, 1'b0);
        chk("s4_step7", 64'(step_o), 64'd7);
        edge_step(1'b1, 1'b1);
        chk("s4_clr_step", 64'(step_o), 64'd0);
        chk("s4_clr_cnt", 64'(cnt_o), 64'd0);
        chk("s4_clr_fire", 64'(fire_o), 64'd0);
        for (int k = 0; k < 3; k++) edge_step(1'b1, 1'b0);
        chk("s4_fire0_at3", 64'(fire_o[0]), 64'd1);

        // 5: 4-bit step wraps, phases keep counting enabled edges
        edge_step(1'b0, 1'b1);
        for (int k = 0; k < 18; k++) edge_step(1'b1, 1'b0);
        chk("s5_step4", 64'(step2_o), 64'd2);
        chk("s5_fire4", 64'(fire2_o[0]), 64'd1);

        // 6: asynchronous reset between edges
        edge_step(1'b0, 1'b1);
        for (int k = 0; k < 12; k++) edge_step(1'b1, 1'b0);
        chk("s6_cnt_pre", 64'(cnt_o), 64'h0204);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("s6_async");
        #2;
        rst = 1'b1;
        m_reset();
        edge_step(1'b1, 1'b0);
        chk("s6_step1", 64'(step_o), 64'd1);
        chk("s6_fire", 64'(fire_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
